// File: rtl/axi_bench_gen_if.sv
// AXI4 master-side channel bundle for the benchmark traffic generator.
// The master modport belongs to the generator, the slave modport to the memory side.
interface axi_bench_gen_if #(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 1
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic [ID_WIDTH-1:0]     arid;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [ID_WIDTH-1:0]     awid;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arlen, arsize, arburst, arid, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awid, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arid, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awid, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_bench_gen.sv
// AXI4 read-only / write-only burst traffic generator for one memory channel.
// Issues num_ops INCR bursts at base_addr + i*stride, bounded by MAX_OUTSTANDING, and measures the run.
module axi_bench_gen #(
    parameter int ADDR_WIDTH      = 33,
    parameter int DATA_WIDTH      = 512,
    parameter int ID_WIDTH        = 1,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [7:0]            burst_len,
    input  logic [31:0]           num_ops,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [47:0]           cycles,
    output logic [47:0]           beats,
    axi_bench_gen_if.master       axi
);
    localparam logic [2:0] SIZE_VAL = 3'($clog2(DATA_WIDTH / 8));
    localparam int         PW       = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] next_addr_q;
    logic [7:0]            len_q;
    logic [31:0]           num_q;
    logic [31:0]           issued_q;
    logic [31:0]           completed_q;
    logic [31:0]           completed_next;
    logic [PW-1:0]         pending_w_q;
    logic [7:0]            wbeat_q;
    logic                  avalid_q;

    logic a_hs, r_hs, w_hs, b_hs, cpl, can_issue, load;
    logic wvalid_int, wlast_int;
    logic unused_rdata;

    assign a_hs       = avalid_q && (mode_q ? axi.awready : axi.arready);
    assign r_hs       = axi.rvalid && axi.rready;
    assign w_hs       = wvalid_int && axi.wready;
    assign b_hs       = axi.bvalid && axi.bready;
    assign cpl        = mode_q ? b_hs : (r_hs && axi.rlast);
    assign completed_next = completed_q + 32'(cpl);

    // issued counts bursts as soon as they are presented, so the presented one already holds a slot
    assign can_issue  = (issued_q < num_q) &&
                        ((issued_q - completed_q) < 32'(MAX_OUTSTANDING));
    assign load       = (state_q == RUN) && (!avalid_q || a_hs) && can_issue;

    assign wvalid_int = (state_q == RUN) && mode_q && (pending_w_q != '0);
    assign wlast_int  = wvalid_int && (wbeat_q == len_q);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (num_ops == 32'd0) ? DONE : RUN;
            RUN:  if (completed_next == num_q) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            mode_q      <= 1'b0;
            stride_q    <= '0;
            addr_q      <= '0;
            next_addr_q <= '0;
            len_q       <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            pending_w_q <= '0;
            wbeat_q     <= '0;
            avalid_q    <= 1'b0;
            err         <= 1'b0;
            cycles      <= '0;
            beats       <= '0;
        end else if (state_q == IDLE && start) begin
            mode_q      <= mode;
            stride_q    <= stride;
            len_q       <= burst_len;
            num_q       <= num_ops;
            completed_q <= '0;
            pending_w_q <= '0;
            wbeat_q     <= '0;
            err         <= 1'b0;
            cycles      <= '0;
            beats       <= '0;
            // First burst is presented straight away so valid rises the cycle after acceptance
            if (num_ops != 32'd0) begin
                avalid_q    <= 1'b1;
                addr_q      <= base_addr;
                next_addr_q <= base_addr + stride;
                issued_q    <= 32'd1;
            end else begin
                avalid_q    <= 1'b0;
                issued_q    <= '0;
            end
        end else if (state_q == RUN) begin
            cycles      <= cycles + 48'd1;
            completed_q <= completed_next;
            if (load) begin
                avalid_q    <= 1'b1;
                addr_q      <= next_addr_q;
                next_addr_q <= next_addr_q + stride_q;
                issued_q    <= issued_q + 32'd1;
            end else if (a_hs) begin
                avalid_q <= 1'b0;
            end
            if (r_hs || w_hs) beats <= beats + 48'd1;
            if ((r_hs && axi.rresp != 2'b00) || (b_hs && axi.bresp != 2'b00)) err <= 1'b1;
            case ({a_hs && mode_q, w_hs && wlast_int})
                2'b10:   pending_w_q <= pending_w_q + PW'(1);
                2'b01:   pending_w_q <= pending_w_q - PW'(1);
                default: pending_w_q <= pending_w_q;
            endcase
            if (w_hs) wbeat_q <= wlast_int ? 8'd0 : wbeat_q + 8'd1;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    // Address payloads are zeroed while idle so the unused channel stays quiet
    assign axi.arvalid = avalid_q && !mode_q;
    assign axi.araddr  = axi.arvalid ? addr_q   : '0;
    assign axi.arlen   = axi.arvalid ? len_q    : '0;
    assign axi.arsize  = axi.arvalid ? SIZE_VAL : '0;
    assign axi.arburst = 2'b01;
    assign axi.arid    = '0;

    assign axi.awvalid = avalid_q && mode_q;
    assign axi.awaddr  = axi.awvalid ? addr_q   : '0;
    assign axi.awlen   = axi.awvalid ? len_q    : '0;
    assign axi.awsize  = axi.awvalid ? SIZE_VAL : '0;
    assign axi.awburst = 2'b01;
    assign axi.awid    = '0;

    assign axi.wvalid  = wvalid_int;
    assign axi.wlast   = wlast_int;
    assign axi.wdata   = {(DATA_WIDTH / 32){beats[31:0]}};
    assign axi.wstrb   = wvalid_int ? '1 : '0;

    assign axi.rready  = (state_q == RUN) && !mode_q;
    assign axi.bready  = (state_q == RUN) && mode_q;

    assign unused_rdata = ^axi.rdata;
endmodule

// File: tb/tb_axi_bench_gen.sv
// Self-checking bench for axi_bench_gen: reactive AXI slave plus address/write-data scoreboard.
module tb_axi_bench_gen;
    localparam int AW = 33;
    localparam int DW = 512;
    localparam int IW = 1;
    localparam int MO = 16;

    logic          clk = 1'b0;
    logic          arst;
    logic          start;
    logic          mode;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] stride;
    logic [7:0]    burst_len;
    logic [31:0]   num_ops;
    logic          busy, done, err;
    logic [47:0]   cycles, beats;

    always #5 clk = ~clk;

    axi_bench_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

    axi_bench_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .arst(arst), .start(start), .mode(mode),
        .base_addr(base_addr), .stride(stride), .burst_len(burst_len), .num_ops(num_ops),
        .busy(busy), .done(done), .err(err), .cycles(cycles), .beats(beats),
        .axi(axi)
    );

    int errors = 0;
    int checks = 0;

    // slave behaviour knobs
    bit r_hold        = 1'b0;
    bit wready_toggle = 1'b0;
    int bresp_err_idx = -1;

    // scoreboard
    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_wbeat_q[$];
    bit            exp_wlast_q[$];
    logic [7:0]    exp_len;

    int ar_hs_cnt, aw_hs_cnt, r_hs_cnt, w_hs_cnt, b_hs_cnt, done_cnt;
    int r_len_q[$];
    int r_beat;
    int b_pend;

    // Slave: at each falling edge decide this cycle's drives, then commit the handshakes
    // that the next rising edge will complete.
    initial begin
        forever begin
            @(negedge clk);
            if (arst) begin
                axi.arready = 0; axi.awready = 0; axi.wready = 0;
                axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0; axi.rdata = '0;
                axi.bvalid = 0; axi.bresp = 0;
                r_len_q.delete(); r_beat = 0; b_pend = 0;
            end else begin
                axi.arready = 1'b1;
                axi.awready = 1'b1;
                axi.wready  = wready_toggle ? ~axi.wready : 1'b1;
                if (r_len_q.size() > 0 && !r_hold) begin
                    axi.rvalid = 1'b1;
                    axi.rlast  = (r_beat == r_len_q[0]);
                    axi.rresp  = 2'b00;
                    axi.rdata  = {(DW/32){32'(r_beat)}};
                end else begin
                    axi.rvalid = 1'b0;
                    axi.rlast  = 1'b0;
                end
                axi.bvalid = (b_pend > 0);
                axi.bresp  = (b_hs_cnt == bresp_err_idx) ? 2'b10 : 2'b00;

                if (axi.arvalid && axi.arready) begin
                    logic [AW-1:0] e;
                    ar_hs_cnt++;
                    checks++;
                    e = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 'x;
                    if (axi.araddr !== e || axi.arlen !== exp_len || axi.arsize !== 3'd6 ||
                        axi.arburst !== 2'b01 || axi.arid !== '0)
                        begin errors++; $display("FAIL ar_payload: got addr=%h len=%0d size=%0d burst=%b, expected addr=%h len=%0d size=6 burst=01",
                                                 axi.araddr, axi.arlen, axi.arsize, axi.arburst, e, exp_len); end
                    r_len_q.push_back(int'(axi.arlen));
                end
                if (axi.awvalid && axi.awready) begin
                    logic [AW-1:0] e;
                    aw_hs_cnt++;
                    checks++;
                    e = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 'x;
                    if (axi.awaddr !== e || axi.awlen !== exp_len || axi.awsize !== 3'd6 ||
                        axi.awburst !== 2'b01 || axi.awid !== '0)
                        begin errors++; $display("FAIL aw_payload: got addr=%h len=%0d size=%0d burst=%b, expected addr=%h len=%0d size=6 burst=01",
                                                 axi.awaddr, axi.awlen, axi.awsize, axi.awburst, e, exp_len); end
                end
                if (axi.rvalid && axi.rready) begin
                    r_hs_cnt++;
                    if (axi.rlast) begin void'(r_len_q.pop_front()); r_beat = 0; end
                    else r_beat++;
                end
                if (axi.wvalid && axi.wready) begin
                    logic [31:0]   ev;
                    bit            el;
                    logic [DW-1:0] ed;
                    w_hs_cnt++;
                    checks++;
                    ev = (exp_wbeat_q.size() > 0) ? exp_wbeat_q.pop_front() : 'x;
                    el = (exp_wlast_q.size() > 0) ? exp_wlast_q.pop_front() : 1'b0;
                    ed = {(DW/32){ev}};
                    if (axi.wdata !== ed || axi.wlast !== el || axi.wstrb !== {(DW/8){1'b1}})
                        begin errors++; $display("FAIL w_beat: got word0=%h wlast=%b strb_ok=%b, expected word0=%h wlast=%b strb all ones",
                                                 axi.wdata[31:0], axi.wlast, (axi.wstrb === {(DW/8){1'b1}}), ev, el); end
                    if (axi.wlast) b_pend++;
                end
                if (axi.bvalid && axi.bready) begin
                    b_hs_cnt++;
                    b_pend--;
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic start_run(input bit m, input logic [AW-1:0] base, input logic [AW-1:0] str,
                             input logic [7:0] len, input logic [31:0] n);
        ar_hs_cnt = 0; aw_hs_cnt = 0; r_hs_cnt = 0; w_hs_cnt = 0; b_hs_cnt = 0; done_cnt = 0;
        exp_len = len;
        @(negedge clk);
        mode = m; base_addr = base; stride = str; burst_len = len; num_ops = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        int n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL %s_done: got done=%b busy=%b after %0d cycles, expected done=1 busy=0", name, done, busy, n); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0)
            begin errors++; $display("FAIL %s_done_width: got done=%b one cycle later, expected 0", name, done); end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({busy, done, err, axi.arvalid, axi.awvalid, axi.wvalid, axi.wlast, axi.rready, axi.bready} !== 9'b0 ||
            cycles !== 48'd0 || beats !== 48'd0)
            begin errors++; $display("FAIL reset_ctrl: got busy=%b done=%b err=%b arv=%b awv=%b wv=%b cycles=%0d beats=%0d, expected all 0",
                                     busy, done, err, axi.arvalid, axi.awvalid, axi.wvalid, cycles, beats); end
        checks++;
        if (axi.araddr !== '0 || axi.awaddr !== '0 || axi.arlen !== 8'd0 || axi.awlen !== 8'd0 ||
            axi.arsize !== 3'd0 || axi.awsize !== 3'd0 || axi.wdata !== '0 || axi.wstrb !== '0 ||
            axi.arburst !== 2'b01 || axi.awburst !== 2'b01)
            begin errors++; $display("FAIL reset_payload: got araddr=%h arsize=%0d arburst=%b awburst=%b wstrb_zero=%b, expected 0 payloads and burst 01",
                                     axi.araddr, axi.arsize, axi.arburst, axi.awburst, (axi.wstrb === '0)); end
        @(negedge clk);
        arst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_basic;
        exp_addr_q.push_back(33'h1000);
        exp_addr_q.push_back(33'h1040);
        exp_addr_q.push_back(33'h1080);
        exp_addr_q.push_back(33'h10C0);
        start_run(1'b0, 33'h1000, 33'h40, 8'd0, 32'd4);
        checks++;
        if (busy !== 1'b1 || axi.arvalid !== 1'b1 || axi.awvalid !== 1'b0)
            begin errors++; $display("FAIL read_accept: got busy=%b arvalid=%b awvalid=%b, expected 1 1 0", busy, axi.arvalid, axi.awvalid); end
        wait_done(50, "read_basic");
        @(negedge clk);
        checks++;
        if (beats !== 48'd4 || err !== 1'b0 || cycles !== 48'd5 || done_cnt != 1 ||
            ar_hs_cnt != 4 || r_hs_cnt != 4 || exp_addr_q.size() != 0)
            begin errors++; $display("FAIL read_basic_stats: got beats=%0d err=%b cycles=%0d dones=%0d ar=%0d r=%0d left=%0d, expected 4 0 5 1 4 4 0",
                                     beats, err, cycles, done_cnt, ar_hs_cnt, r_hs_cnt, exp_addr_q.size()); end
    endtask

    task automatic test_outstanding;
        for (int i = 0; i < 40; i++) exp_addr_q.push_back(33'h20000 + AW'(i) * 33'h40);
        r_hold = 1'b1;
        start_run(1'b0, 33'h20000, 33'h40, 8'd0, 32'd40);
        repeat (30) @(negedge clk);
        checks++;
        if (ar_hs_cnt != MO || axi.arvalid !== 1'b0 || r_hs_cnt != 0)
            begin errors++; $display("FAIL outstanding_limit: got ar=%0d arvalid=%b r=%0d, expected ar=16 arvalid=0 r=0", ar_hs_cnt, axi.arvalid, r_hs_cnt); end
        r_hold = 1'b0;
        wait_done(400, "outstanding");
        checks++;
        if (beats !== 48'd40 || ar_hs_cnt != 40 || exp_addr_q.size() != 0 || err !== 1'b0)
            begin errors++; $display("FAIL outstanding_stats: got beats=%0d ar=%0d left=%0d err=%b, expected 40 40 0 0",
                                     beats, ar_hs_cnt, exp_addr_q.size(), err); end
    endtask

    task automatic test_write;
        exp_addr_q.push_back(33'h2000);
        exp_addr_q.push_back(33'h2100);
        for (int k = 0; k < 8; k++) begin
            exp_wbeat_q.push_back(32'(k));
            exp_wlast_q.push_back(k == 3 || k == 7);
        end
        wready_toggle = 1'b1;
        start_run(1'b1, 33'h2000, 33'h100, 8'd3, 32'd2);
        checks++;
        if (busy !== 1'b1 || axi.awvalid !== 1'b1 || axi.arvalid !== 1'b0 || axi.wvalid !== 1'b0)
            begin errors++; $display("FAIL write_accept: got busy=%b awvalid=%b arvalid=%b wvalid=%b, expected 1 1 0 0",
                                     busy, axi.awvalid, axi.arvalid, axi.wvalid); end
        wait_done(200, "write");
        @(negedge clk);
        wready_toggle = 1'b0;
        checks++;
        if (w_hs_cnt != 8 || b_hs_cnt != 2 || beats !== 48'd8 || err !== 1'b0 || done_cnt != 1 ||
            ar_hs_cnt != 0 || exp_addr_q.size() != 0 || exp_wbeat_q.size() != 0)
            begin errors++; $display("FAIL write_stats: got w=%0d b=%0d beats=%0d err=%b dones=%0d ar=%0d, expected 8 2 8 0 1 0",
                                     w_hs_cnt, b_hs_cnt, beats, err, done_cnt, ar_hs_cnt); end
    endtask

    task automatic test_bresp_err;
        exp_addr_q.push_back(33'h3000);
        exp_addr_q.push_back(33'h3040);
        exp_addr_q.push_back(33'h3080);
        for (int k = 0; k < 3; k++) begin
            exp_wbeat_q.push_back(32'(k));
            exp_wlast_q.push_back(1'b1);
        end
        bresp_err_idx = 1;
        start_run(1'b1, 33'h3000, 33'h40, 8'd0, 32'd3);
        wait_done(200, "bresp");
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || b_hs_cnt != 3 || done_cnt != 1 || beats !== 48'd3)
            begin errors++; $display("FAIL bresp_err: got err=%b b=%0d dones=%0d beats=%0d, expected 1 3 1 3", err, b_hs_cnt, done_cnt, beats); end
        bresp_err_idx = -1;
        exp_addr_q.push_back(33'h5000);
        start_run(1'b0, 33'h5000, 33'h40, 8'd0, 32'd1);
        checks++;
        if (err !== 1'b0)
            begin errors++; $display("FAIL err_clear: got err=%b after new start, expected 0", err); end
        wait_done(50, "err_clear");
        checks++;
        if (err !== 1'b0 || beats !== 48'd1)
            begin errors++; $display("FAIL err_clear_run: got err=%b beats=%0d, expected 0 1", err, beats); end
    endtask

    task automatic test_wrap;
        exp_addr_q.push_back(33'h1_FFFF_FFC0);
        exp_addr_q.push_back(33'h0_0000_0000);
        start_run(1'b0, 33'h1_FFFF_FFC0, 33'h40, 8'd0, 32'd2);
        wait_done(50, "wrap");
        checks++;
        if (ar_hs_cnt != 2 || exp_addr_q.size() != 0 || err !== 1'b0)
            begin errors++; $display("FAIL wrap: got ar=%0d left=%0d err=%b, expected 2 0 0", ar_hs_cnt, exp_addr_q.size(), err); end
    endtask

    task automatic test_zero_ops;
        start_run(1'b0, 33'h100, 33'h40, 8'd0, 32'd0);
        checks++;
        if (busy !== 1'b0 || axi.arvalid !== 1'b0)
            begin errors++; $display("FAIL zero_ops_accept: got busy=%b arvalid=%b, expected 0 0", busy, axi.arvalid); end
        wait_done(2, "zero_ops");
        checks++;
        if (cycles !== 48'd0 || beats !== 48'd0 || ar_hs_cnt != 0 || aw_hs_cnt != 0)
            begin errors++; $display("FAIL zero_ops: got cycles=%0d beats=%0d ar=%0d aw=%0d, expected all 0", cycles, beats, ar_hs_cnt, aw_hs_cnt); end
    endtask

    task automatic test_reset_midrun;
        int n = 0;
        for (int i = 0; i < 40; i++) exp_addr_q.push_back(33'h40000 + AW'(i) * 33'h40);
        r_hold = 1'b1;
        start_run(1'b0, 33'h40000, 33'h40, 8'd0, 32'd40);
        while (ar_hs_cnt < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ar_hs_cnt != 5)
            begin errors++; $display("FAIL midrun_setup: got ar=%0d, expected 5", ar_hs_cnt); end
        @(posedge clk);
        #1 arst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 8'b0 ||
            cycles !== 48'd0 || beats !== 48'd0 || axi.araddr !== '0 || axi.arlen !== 8'd0 ||
            axi.arsize !== 3'd0 || axi.arburst !== 2'b01 || axi.awburst !== 2'b01)
            begin errors++; $display("FAIL midrun_reset: got busy=%b arvalid=%b rready=%b cycles=%0d araddr=%h arburst=%b, expected 0 0 0 0 0 01",
                                     busy, axi.arvalid, axi.rready, cycles, axi.araddr, axi.arburst); end
        @(negedge clk);
        #1 arst = 1'b0;
        r_hold = 1'b0;
        exp_addr_q.delete();
        exp_addr_q.push_back(33'h8000);
        exp_addr_q.push_back(33'h8040);
        exp_addr_q.push_back(33'h8080);
        exp_addr_q.push_back(33'h80C0);
        start_run(1'b0, 33'h8000, 33'h40, 8'd0, 32'd4);
        wait_done(50, "after_reset");
        checks++;
        if (beats !== 48'd4 || ar_hs_cnt != 4 || exp_addr_q.size() != 0 || cycles !== 48'd5)
            begin errors++; $display("FAIL after_reset_run: got beats=%0d ar=%0d left=%0d cycles=%0d, expected 4 4 0 5",
                                     beats, ar_hs_cnt, exp_addr_q.size(), cycles); end
    endtask

    initial begin
        arst = 1'b1;
        start = 1'b0; mode = 1'b0; base_addr = '0; stride = '0; burst_len = '0; num_ops = '0;
        axi.arready = 0; axi.awready = 0; axi.wready = 0;
        axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0; axi.rdata = '0;
        axi.bvalid = 0; axi.bresp = 0;
        test_reset();
        test_read_basic();
        test_outstanding();
        test_write();
        test_bresp_err();
        test_wrap();
        test_zero_ops();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
